// File: rtl/kpc_pkg.sv
// Shared types and constants for the keyboard press classifier: event and key-state
// encodings, game scan codes and the default watched-key table.
package kpc_pkg;

  typedef enum logic [1:0] {
    EV_SHORT  = 2'd0,
    EV_LONG   = 2'd1,
    EV_REPEAT = 2'd2
  } ev_type_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } key_state_t;

  localparam logic [8:0] SC_W       = 9'h01D;
  localparam logic [8:0] SC_A       = 9'h01C;
  localparam logic [8:0] SC_S       = 9'h01B;
  localparam logic [8:0] SC_D       = 9'h023;
  localparam logic [8:0] SC_LSHIFT  = 9'h012;
  localparam logic [8:0] SC_RSHIFT  = 9'h059;
  localparam logic [8:0] SC_SPACE   = 9'h029;
  localparam logic [8:0] SC_BKSPACE = 9'h066;
  localparam logic [8:0] SC_O       = 9'h044;
  localparam logic [8:0] SC_K       = 9'h042;
  localparam logic [8:0] SC_L       = 9'h04B;
  localparam logic [8:0] SC_COLON   = 9'h04C;

  // Entry 0 sits in the least significant 9 bits.
  localparam logic [12*9-1:0] DEFAULT_KEY_CODES = {
    SC_COLON, SC_L, SC_K, SC_O, SC_BKSPACE, SC_SPACE,
    SC_RSHIFT, SC_LSHIFT, SC_D, SC_S, SC_A, SC_W
  };

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kpc_event_fifo.sv
// Synchronous event FIFO. Output side is valid/ready: an entry leaves on a clock edge
// where valid and ready are both high; data holds stable while valid=1 and ready=0.
module kpc_event_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             wr_en, rd_en;

  assign full  = (count == FULL_CNT);
  assign valid = (count != '0);
  assign wr_en = push && !full;
  assign rd_en = valid && ready;
  // Empty head reads as zero so stale memory never shows on the outputs.
  assign data  = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keyboard_press_classifier.sv
// Watches N_KEYS scan codes and classifies holds into SHORT/LONG(/REPEAT) events,
// as per-key pulses and an ordered FIFO stream. Define KPC_AUTOREPEAT_EN for REPEAT events.
module keyboard_press_classifier
  import kpc_pkg::*;
#(
  parameter int                  N_KEYS       = 12,
  parameter logic [N_KEYS*9-1:0] KEY_CODES    = DEFAULT_KEY_CODES[N_KEYS*9-1:0],
  parameter int                  CNT_WIDTH    = 4,
  parameter int                  LONG_TICKS   = 8,
  parameter int                  REPEAT_TICKS = 4,
  parameter int                  FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic [511:0]                  key_down,
  output logic [N_KEYS-1:0]             s_pulse,
  output logic [N_KEYS-1:0]             l_pulse,
  output logic [N_KEYS-1:0]             held,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [idx_width(N_KEYS)-1:0]  ev_key,
  output logic [1:0]                    ev_type,
  output logic                          ev_overflow
);

  localparam int KW = idx_width(N_KEYS);
  localparam logic [CNT_WIDTH-1:0] LONG_CNT   = LONG_TICKS[CNT_WIDTH-1:0];
  localparam logic [CNT_WIDTH-1:0] REPEAT_CNT = REPEAT_TICKS[CNT_WIDTH-1:0];

  if (N_KEYS < 1 || N_KEYS > 32 ||
      LONG_TICKS < 1 || LONG_TICKS > (2**CNT_WIDTH - 1) ||
      REPEAT_TICKS < 1 || REPEAT_TICKS > (2**CNT_WIDTH - 1) ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("keyboard_press_classifier: illegal parameter combination");
  end

  logic [N_KEYS-1:0]      pend_v;
  logic [N_KEYS-1:0][1:0] ptype_v;
  logic [N_KEYS-1:0]      grant;
  logic [N_KEYS-1:0]      ovf_req;
  logic [KW-1:0]          grant_idx;
  logic                   push;
  logic                   fifo_full;
  logic [KW+1:0]          fifo_head;
  logic                   unused_key_map;

  assign unused_key_map = ^key_down;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_state_t           state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt, cnt_inc;
    logic                 key_in, fire;
    ev_type_t             kind;
    logic                 s_q, l_q, pend_q;
    ev_type_t             ptype_q;

    assign key_in  = key_down[KEY_CODES[9*i +: 9]];
    assign cnt_inc = cnt + 1'b1;

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      fire      = 1'b0;
      kind      = EV_SHORT;
      if (tick) begin
        case (state)
          IDLE: begin
            if (key_in) begin
              state_nxt = PRESS;
              cnt_nxt   = '0;
            end
          end
          PRESS: begin
            if (!key_in) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
              fire      = 1'b1;
              kind      = EV_SHORT;
            end else if (cnt_inc == LONG_CNT) begin
              state_nxt = LONG;
              cnt_nxt   = '0;
              fire      = 1'b1;
              kind      = EV_LONG;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end
          LONG: begin
            if (!key_in) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end else begin
`ifdef KPC_AUTOREPEAT_EN
              if (cnt_inc == REPEAT_CNT) begin
                cnt_nxt = '0;
                fire    = 1'b1;
                kind    = EV_REPEAT;
              end else begin
                cnt_nxt = cnt_inc;
              end
`else
              // No repeat: the counter only saturates while the key stays down.
              if (!(&cnt) && (REPEAT_CNT != '0)) cnt_nxt = cnt_inc;
`endif
            end
          end
          default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state   <= IDLE;
        cnt     <= '0;
        s_q     <= 1'b0;
        l_q     <= 1'b0;
        pend_q  <= 1'b0;
        ptype_q <= EV_SHORT;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
        s_q   <= fire && (kind == EV_SHORT);
        l_q   <= fire && (kind != EV_SHORT);
        // A grant this cycle frees the slot, so a coincident new event is kept.
        if (fire && (!pend_q || grant[i])) begin
          pend_q  <= 1'b1;
          ptype_q <= kind;
        end else if (grant[i]) begin
          pend_q <= 1'b0;
        end
      end
    end

    assign ovf_req[i] = fire && pend_q && !grant[i];
    assign s_pulse[i] = s_q;
    assign l_pulse[i] = l_q;
    assign held[i]    = (state != IDLE);
    assign pend_v[i]  = pend_q;
    assign ptype_v[i] = ptype_q;
  end

  // Lowest pending index wins; nothing is granted while the FIFO is full.
  always_comb begin
    push      = 1'b0;
    grant_idx = '0;
    if (!fifo_full) begin
      for (int k = N_KEYS - 1; k >= 0; k--) begin
        if (pend_v[k]) begin
          push      = 1'b1;
          grant_idx = k[KW-1:0];
        end
      end
    end
    grant = push ? (N_KEYS'(1) << grant_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) ev_overflow <= 1'b0;
    else if (|ovf_req) ev_overflow <= 1'b1;
  end

  kpc_event_fifo #(
    .WIDTH (KW + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({grant_idx, ptype_v[grant_idx]}),
    .full      (fifo_full),
    .valid     (ev_valid),
    .ready     (ev_ready),
    .data      (fifo_head)
  );

  assign ev_key  = fifo_head[KW+1:2];
  assign ev_type = fifo_head[1:0];

endmodule

// File: tb/tb_keyboard_press_classifier.sv
// Directed bench for keyboard_press_classifier with four watched keys (W, A, S, D).
// Honors KPC_AUTOREPEAT_EN to select the expected REPEAT behaviour.
module tb_keyboard_press_classifier;
  import kpc_pkg::*;

  localparam int N = 4;
  localparam logic [N*9-1:0] CODES = {SC_D, SC_S, SC_A, SC_W};
`ifdef KPC_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic [511:0] key_down;
  logic         ev_ready;
  logic [N-1:0] s_pulse, l_pulse, held;
  logic         ev_valid, ev_overflow;
  logic [1:0]   ev_key, ev_type;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          s_cnt, l_cnt;
  logic [3:0]  got_q[$];
  logic [3:0]  exp_q[$];
  logic [8:0]  code_tab [N];

  always #5 clk = ~clk;

  keyboard_press_classifier #(
    .N_KEYS       (N),
    .KEY_CODES    (CODES),
    .CNT_WIDTH    (4),
    .LONG_TICKS   (8),
    .REPEAT_TICKS (4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .key_down    (key_down),
    .s_pulse     (s_pulse),
    .l_pulse     (l_pulse),
    .held        (held),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_key      (ev_key),
    .ev_type     (ev_type),
    .ev_overflow (ev_overflow)
  );

  // Log accepted entries and pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (ev_valid && ev_ready) got_q.push_back({ev_key, ev_type});
      s_cnt += $countones(s_pulse);
      l_cnt += $countones(l_pulse);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic set_key(input int k, input bit v);
    key_down[code_tab[k]] = v;
  endtask

  task automatic clear_log();
    got_q.delete();
    exp_q.delete();
    s_cnt = 0;
    l_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b0; key_down = '0; ev_ready = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    n_checks++; if (s_pulse !== 4'b0) begin n_fail++; $display("FAIL reset_s_pulse: got %b want 0000", s_pulse); end
    n_checks++; if (l_pulse !== 4'b0) begin n_fail++; $display("FAIL reset_l_pulse: got %b want 0000", l_pulse); end
    n_checks++; if (held !== 4'b0) begin n_fail++; $display("FAIL reset_held: got %b want 0000", held); end
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ev_valid: got %b want 0", ev_valid); end
    n_checks++; if (ev_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ev_overflow: got %b want 0", ev_overflow); end
    n_checks++; if ({ev_key, ev_type} !== 4'b0) begin n_fail++; $display("FAIL reset_ev_head: got %b want 0000", {ev_key, ev_type}); end
  endtask

  task automatic test_short();
    clear_log();
    set_key(1, 1'b1);
    do_tick();
    n_checks++; if (held !== 4'b0010) begin n_fail++; $display("FAIL short_held: got %b want 0010", held); end
    do_tick(); do_tick();
    set_key(1, 1'b0);
    do_tick();
    n_checks++; if (s_pulse !== 4'b0010) begin n_fail++; $display("FAIL short_pulse: got %b want 0010", s_pulse); end
    n_checks++; if (held !== 4'b0000) begin n_fail++; $display("FAIL short_held_release: got %b want 0000", held); end
    cyc();
    n_checks++; if (s_pulse !== 4'b0000) begin n_fail++; $display("FAIL short_pulse_width: got %b want 0000", s_pulse); end
    repeat (4) cyc();
    exp_q.push_back({2'd1, 2'd0});
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL short_entries: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_checks++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL short_entry%0d: got %b want %b", k, got_q[k], exp_q[k]); end
    end
    n_checks++; if (l_cnt != 0) begin n_fail++; $display("FAIL short_no_l_pulse: got %0d want 0", l_cnt); end
    n_checks++; if (s_cnt != 1) begin n_fail++; $display("FAIL short_s_count: got %0d want 1", s_cnt); end
  endtask

  task automatic test_long();
    logic exp_l;
    clear_log();
    set_key(0, 1'b1);
    do_tick();
    for (int n = 1; n <= 20; n++) begin
      do_tick();
      exp_l = (n == 8) || (AR && n > 8 && ((n - 8) % 4 == 0));
      n_checks++; if (l_pulse !== {3'b000, exp_l}) begin n_fail++; $display("FAIL long_l_pulse_t%0d: got %b want %b", n, l_pulse, {3'b000, exp_l}); end
    end
    set_key(0, 1'b0);
    do_tick();
    n_checks++; if (s_pulse !== 4'b0) begin n_fail++; $display("FAIL long_release_s: got %b want 0000", s_pulse); end
    n_checks++; if (held !== 4'b0) begin n_fail++; $display("FAIL long_release_held: got %b want 0000", held); end
    repeat (4) cyc();
    exp_q.push_back({2'd0, 2'd1});
    if (AR) repeat (3) exp_q.push_back({2'd0, 2'd2});
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL long_entries: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_checks++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL long_entry%0d: got %b want %b", k, got_q[k], exp_q[k]); end
    end
    n_checks++; if (s_cnt != 0) begin n_fail++; $display("FAIL long_no_short: got %0d want 0", s_cnt); end
  endtask

  task automatic test_simultaneous();
    clear_log();
    set_key(0, 1'b1); set_key(2, 1'b1); set_key(3, 1'b1);
    do_tick(); do_tick();
    set_key(0, 1'b0); set_key(2, 1'b0); set_key(3, 1'b0);
    do_tick();
    n_checks++; if (s_pulse !== 4'b1101) begin n_fail++; $display("FAIL simul_pulses: got %b want 1101", s_pulse); end
    cyc();
    n_checks++; if ({ev_valid, ev_key, ev_type} !== 5'b1_00_00) begin n_fail++; $display("FAIL simul_first: got %b want 10000", {ev_valid, ev_key, ev_type}); end
    cyc();
    n_checks++; if ({ev_valid, ev_key, ev_type} !== 5'b1_10_00) begin n_fail++; $display("FAIL simul_second: got %b want 11000", {ev_valid, ev_key, ev_type}); end
    cyc();
    n_checks++; if ({ev_valid, ev_key, ev_type} !== 5'b1_11_00) begin n_fail++; $display("FAIL simul_third: got %b want 11100", {ev_valid, ev_key, ev_type}); end
    cyc();
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL simul_drained: got %b want 0", ev_valid); end
  endtask

  task automatic test_overflow();
    clear_log();
    ev_ready = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      set_key(3, 1'b1); do_tick();
      set_key(3, 1'b0); do_tick();
      cyc(); cyc();
      n_checks++; if (ev_overflow !== (n == 6)) begin n_fail++; $display("FAIL ovf_flag_ev%0d: got %b want %b", n, ev_overflow, (n == 6)); end
      n_checks++; if ({ev_valid, ev_key, ev_type} !== 5'b1_11_00) begin n_fail++; $display("FAIL ovf_head_ev%0d: got %b want 11100", n, {ev_valid, ev_key, ev_type}); end
    end
    ev_ready = 1'b1;
    repeat (8) cyc();
    n_checks++; if (got_q.size() != 5) begin n_fail++; $display("FAIL ovf_drained: got %0d want 5", got_q.size()); end
    for (int k = 0; k < got_q.size(); k++) begin
      n_checks++; if (got_q[k] !== 4'b1100) begin n_fail++; $display("FAIL ovf_entry%0d: got %b want 1100", k, got_q[k]); end
    end
    n_checks++; if (ev_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", ev_overflow); end
    rst = 1'b1; cyc(); rst = 1'b0;
    n_checks++; if (ev_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared: got %b want 0", ev_overflow); end
  endtask

  task automatic test_reset_mid();
    clear_log();
    ev_ready = 1'b0;
    set_key(0, 1'b1); do_tick();
    set_key(0, 1'b0); do_tick();
    set_key(2, 1'b1); do_tick();
    repeat (8) do_tick();
    cyc(); cyc();
    n_checks++; if ({ev_valid, ev_key, ev_type} !== 5'b1_00_00) begin n_fail++; $display("FAIL rmid_head: got %b want 10000", {ev_valid, ev_key, ev_type}); end
    n_checks++; if (held !== 4'b0100) begin n_fail++; $display("FAIL rmid_held_before: got %b want 0100", held); end
    rst = 1'b1; cyc(); rst = 1'b0;
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_ev_valid: got %b want 0", ev_valid); end
    n_checks++; if (held !== 4'b0000) begin n_fail++; $display("FAIL rmid_held_after: got %b want 0000", held); end
    ev_ready = 1'b1;
    clear_log();
    do_tick();
    n_checks++; if (held !== 4'b0100) begin n_fail++; $display("FAIL rmid_repress: got %b want 0100", held); end
    for (int n = 1; n <= 8; n++) begin
      do_tick();
      n_checks++; if (l_pulse !== ((n == 8) ? 4'b0100 : 4'b0000)) begin n_fail++; $display("FAIL rmid_long_t%0d: got %b", n, l_pulse); end
    end
    set_key(2, 1'b0); do_tick();
    repeat (4) cyc();
    n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL rmid_entries: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_checks++; if (got_q[0] !== 4'b1001) begin n_fail++; $display("FAIL rmid_entry: got %b want 1001", got_q[0]); end
    end
  endtask

  task automatic test_no_tick();
    clear_log();
    set_key(0, 1'b1); do_tick();
    n_checks++; if (held !== 4'b0001) begin n_fail++; $display("FAIL notick_entry: got %b want 0001", held); end
    for (int n = 0; n < 12; n++) begin
      set_key(n % 4, (n % 2) == 1);
      cyc();
      n_checks++; if ({s_pulse, l_pulse, held} !== 12'b0000_0000_0001) begin n_fail++; $display("FAIL notick_c%0d: got %b want 000000000001", n, {s_pulse, l_pulse, held}); end
    end
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL notick_ev_valid: got %b want 0", ev_valid); end
    key_down = '0;
    do_tick();
    n_checks++; if ({s_pulse, l_pulse} !== 8'b0001_0000) begin n_fail++; $display("FAIL notick_release: got %b want 00010000", {s_pulse, l_pulse}); end
    repeat (4) cyc();
  endtask

  initial begin
    code_tab[0] = SC_W;
    code_tab[1] = SC_A;
    code_tab[2] = SC_S;
    code_tab[3] = SC_D;
    s_cnt = 0;
    l_cnt = 0;
    test_reset();
    test_short();
    test_long();
    test_simultaneous();
    test_overflow();
    test_reset_mid();
    test_no_tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keyboard_press_classifier.md
# keyboard_press_classifier

Parametrised successor to the fixed 12-key press detector. It takes the 512-bit `key_down` map from the PS/2 keyboard decoder and watches `N_KEYS` run-time-independent scan codes selected by parameter. Each key is classified into short press, long press and (optionally) auto-repeat events. Events appear both as per-key one-cycle pulses and as a serialised event stream through a small FIFO with a valid/ready handshake, so game logic can consume key events in order without missing simultaneous presses.

## Interface
- `N_KEYS`, 12, number of watched keys (1..32)
- `KEY_CODES`, 12 default game codes, `N_KEYS*9` bits; entry i = `KEY_CODES[9*i +: 9]`
- `CNT_WIDTH`, 4, hold-counter width; must satisfy `LONG_TICKS`, `REPEAT_TICKS` <= 2^CNT_WIDTH−1
- `LONG_TICKS`, 8, ticks of continuous hold before LONG event
- `REPEAT_TICKS`, 4, ticks between REPEAT events after LONG
- `FIFO_DEPTH`, 4, event FIFO entries (power of two, >= 2)
- `clk`  in  1  system clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `tick`  in  1  one-`clk` sampling strobe (100 Hz equivalent), synchronous to `clk`
- `key_down`  in  512  decoder key map, level per scan code
- `s_pulse`  out  N_KEYS  one-cycle SHORT pulse per key
- `l_pulse`  out  N_KEYS  one-cycle LONG or REPEAT pulse per key
- `held`  out  N_KEYS  key is in PRESS or LONG state
- `ev_valid`  out  1  FIFO non-empty
- `ev_ready`  in  1  consumer accepts head entry
- `ev_key`  out  $clog2(N_KEYS) (min 1)  key index of head entry
- `ev_type`  out  2  head event type: 0 SHORT, 1 LONG, 2 REPEAT
- `ev_overflow`  out  1  sticky: an event was dropped

## Operation
- Per-key FSM, advanced only on edges where `tick`=1. Input bit is `key_down[KEY_CODES[i]]`.
  - IDLE: key=1 -> PRESS, cnt=0.
  - PRESS: key=0 -> IDLE, emit SHORT. key=1 -> cnt+1; if cnt+1==LONG_TICKS -> LONG, cnt=0, emit LONG.
  - LONG: key=0 -> IDLE, no event. key=1 -> cnt+1; with repeat enabled and cnt+1==REPEAT_TICKS -> emit REPEAT, cnt=0; without it cnt saturates.
- An emitted event pulses `s_pulse[i]` (SHORT) or `l_pulse[i]` (LONG/REPEAT) and sets `pend[i]` with its type.
- Arbiter: each cycle with FIFO not full, pushes the lowest-index pending key and clears its `pend`. At most one push per cycle.
- New event for key i while `pend[i]` is set: new event dropped, `ev_overflow` set, old pending kept.
- FIFO pop on `ev_valid & ev_ready`. Push while full never occurs (arbiter gated by registered full). Simultaneous push and pop when non-full is allowed; count unchanged.
- `ev_key`/`ev_type` hold stable while `ev_valid`=1 and `ev_ready`=0.

## Timing
- Reset: all FSMs IDLE, cnt=0, `pend`=0, FIFO empty. `s_pulse`, `l_pulse`, `held`, `ev_valid`, `ev_overflow` = 0. `ev_key` and `ev_type` = 0.
- `rst` during operation aborts in-flight presses silently and discards FIFO contents. A key still held after reset starts a new press on the next tick.
- Pulses and `held` are registered, high in the cycle after the tick edge, and last exactly 1 `clk`.
- Latency tick edge -> `ev_valid`: 2 cycles (pend, then push), if there is no contention and the FIFO is not full.
- LONG fires on the LONG_TICKS-th tick after the entry tick. REPEAT fires every REPEAT_TICKS ticks thereafter.
- `tick` held high for several cycles is treated as one tick per cycle. The source must guarantee a single-cycle strobe.

## Configuration
- `KPC_AUTOREPEAT_EN` defined: REPEAT events are generated as above.
- Undefined: the LONG state never emits REPEAT, and `l_pulse` fires once per hold. Type code 2 is never produced.

## Structure
- Package `kpc_pkg`: `ev_type_t` (EV_SHORT=0, EV_LONG=1, EV_REPEAT=2), `key_state_t` (IDLE, PRESS, LONG), and scan-code constants (W=9'h01D, A=9'h01C, S=9'h01B, D=9'h023, LSHIFT=9'h012, RSHIFT=9'h059, SPACE=9'h029, BKSPACE=9'h066, O=9'h044, K=9'h042, L=9'h04B, COLON=9'h04C).
- Sub-module `kpc_event_fifo`: synchronous FIFO with parameterised width and depth, plus valid/ready output.
- Per-key FSMs are a generate loop in the top module. The arbiter is a priority encoder in the top module.

## Test plan
Bench parameters: N_KEYS=4, LONG_TICKS=8, REPEAT_TICKS=4, FIFO_DEPTH=4, `ev_ready`=1 unless stated.
- Key 1 held for 3 ticks, then released -> `s_pulse[1]` for one cycle. FIFO delivers one entry {key=1, SHORT}. No `l_pulse`.
- Key 0 held for 20 ticks with `KPC_AUTOREPEAT_EN` -> LONG at tick 8, REPEAT at ticks 12, 16 and 20 (4 entries). No SHORT on release. Without the macro, only the LONG entry.
- Keys 0, 2 and 3 released together at 2 ticks -> FIFO entries in order key 0, 2, 3, all SHORT, on consecutive cycles.
- `ev_ready`=0, and 6 SHORT events on one key, one event per 2 ticks -> 4 entries stored. Next event sits pending, a further one sets `ev_overflow`. The entry head holds stable.
- `rst` pulsed while key 2 is in LONG with 2 entries queued -> next cycle `ev_valid`=0 and `held`=0. The key, still down, gives LONG again 8 ticks later.
- `tick`=0 with keys toggling -> no state change and no pulses.
